// File: rtl/status_reg_t_if.sv
// Status-register port bundle: CTRL/ALU side is the master, status_reg_t is the slave.
interface status_reg_t_if;
  logic [7:0] alu_status_i;
  logic       alu_status_we_i;
  logic [2:0] flag_op_i;
  logic       pull_i;
  logic       pull_rti_i;
  logic [7:0] pull_data_i;
  logic       int_entry_i;
  logic       push_brk_i;
  logic       instr_boundary_i;
  logic       irq_n_i;
  logic       nmi_n_i;
  logic       nmi_ack_i;
  logic [7:0] status_o;
  logic [7:0] push_value_o;
  logic       irq_req_o;
  logic       nmi_req_o;

  modport master (
    output alu_status_i, alu_status_we_i, flag_op_i, pull_i, pull_rti_i, pull_data_i,
           int_entry_i, push_brk_i, instr_boundary_i, irq_n_i, nmi_n_i, nmi_ack_i,
    input  status_o, push_value_o, irq_req_o, nmi_req_o
  );

  modport slave (
    input  alu_status_i, alu_status_we_i, flag_op_i, pull_i, pull_rti_i, pull_data_i,
           int_entry_i, push_brk_i, instr_boundary_i, irq_n_i, nmi_n_i, nmi_ack_i,
    output status_o, push_value_o, irq_req_o, nmi_req_o
  );
endinterface

// File: rtl/status_reg_t.sv
// 6502 processor status register P: flag updates, stack push formatting and interrupt requests.
module status_reg_t #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input logic          clk_i,
  input logic          rst_i,
  status_reg_t_if.slave bus
);

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpClc  = 3'd1,
    OpSec  = 3'd2,
    OpCli  = 3'd3,
    OpSei  = 3'd4,
    OpClv  = 3'd5,
    OpCld  = 3'd6,
    OpSed  = 3'd7
  } flag_op_e;

  // Stored flags; B and bit5 are not real state.
  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic i_eff_q, i_eff_d;
  logic nmi_pend_q, nmi_pend_d;
  logic nmi_prev_q;
  logic nmi_edge;
  flag_op_e flag_op;

  assign flag_op = flag_op_e'(bus.flag_op_i);

  // Next-state for P: pull, else ALU then flag op, then interrupt entry forces I.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (bus.pull_i) begin
      n_d = bus.pull_data_i[7];
      v_d = bus.pull_data_i[6];
      d_d = bus.pull_data_i[3];
      i_d = bus.pull_data_i[2];
      z_d = bus.pull_data_i[1];
      c_d = bus.pull_data_i[0];
    end else begin
      if (bus.alu_status_we_i) begin
        n_d = bus.alu_status_i[7];
        v_d = bus.alu_status_i[6];
        z_d = bus.alu_status_i[1];
        c_d = bus.alu_status_i[0];
      end
      unique case (flag_op)
        OpClc:   c_d = 1'b0;
        OpSec:   c_d = 1'b1;
        OpCli:   i_d = 1'b0;
        OpSei:   i_d = 1'b1;
        OpClv:   v_d = 1'b0;
        OpCld:   d_d = 1'b0;
        OpSed:   d_d = 1'b1;
        default: ;
      endcase
    end
    if (bus.int_entry_i) begin
      i_d = 1'b1;
    end
  end

  // Delayed IRQ mask: samples the pre-update I at opcode fetch; RTI and entry bypass the delay.
  always_comb begin
    i_eff_d = i_eff_q;
    if (bus.instr_boundary_i) begin
      i_eff_d = i_q;
    end
    if (bus.pull_i && bus.pull_rti_i) begin
      i_eff_d = bus.pull_data_i[2];
    end
    if (bus.int_entry_i) begin
      i_eff_d = 1'b1;
    end
  end

  // NMI falling-edge detect; a new edge wins over a coincident ack.
  always_comb begin
    nmi_edge   = nmi_prev_q && !bus.nmi_n_i;
    nmi_pend_d = nmi_edge || (nmi_pend_q && !bus.nmi_ack_i);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q        <= RESET_P[7];
      v_q        <= RESET_P[6];
      d_q        <= RESET_P[3];
      i_q        <= RESET_P[2];
      z_q        <= RESET_P[1];
      c_q        <= RESET_P[0];
      i_eff_q    <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      i_eff_q    <= i_eff_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= bus.nmi_n_i;
    end
  end

  // Outputs: bit5 reads 1, B reads 0 except in the pushed byte.
  always_comb begin
    bus.status_o     = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
    bus.push_value_o = bus.status_o | 8'h20 | {3'b000, bus.push_brk_i, 4'b0000};
    bus.irq_req_o    = !bus.irq_n_i && !i_eff_q;
    bus.nmi_req_o    = nmi_pend_q;
  end

endmodule
